proc_pipe_core: RTL

PROC_PIPE_CORE -- requirements
Module: proc_pipe_core

---
 rtl/proc_pipe_core.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/proc_pipe_core.sv
// proc_pipe_core: a small multi-cycle processor core.
// Instructions and data share one 16-bit memory with a 1-cycle synchronous read.
// Results leave the core through a valid/ready output port.
module proc_pipe_core #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [4:0] OP_OUTM = 5'd1;
  localparam logic [4:0] OP_OUTR = 5'd2;
  localparam logic [4:0] OP_MOV  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_JMP  = 5'd6;
  localparam logic [4:0] OP_JZ   = 5'd7;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {FETCH, EXEC, MEMRD, OUTW, HALT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [15:0]         r_outData;
  logic                r_outValid;
  logic                r_capture;
  logic [ADDR_W-1:0]   r_memAddr;

  logic [4:0]          w_op;
  logic                w_isLdi;
  logic [RIDX_W-1:0]   w_ldiRd;
  logic [RIDX_W-1:0]   w_rd;
  logic [RIDX_W-1:0]   w_rs;
  logic [7:0]          w_imm;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W-1:0]   w_pcInc;
  logic [ADDR_W-1:0]   w_pcNext;

  // Instruction fields come straight off the memory read data during EXEC.
  assign w_op    = imem_rdata[15:11];
  assign w_isLdi = (imem_rdata[15:13] == 3'b110);
  assign w_ldiRd = imem_rdata[8 +: RIDX_W];
  assign w_rd    = imem_rdata[5 +: RIDX_W];
  assign w_rs    = imem_rdata[0 +: RIDX_W];
  assign w_imm   = imem_rdata[7:0];
  assign w_addr  = imem_rdata[ADDR_W-1:0];
  assign w_pcInc = r_pc + ADDR_W'(1);

  // Program counter target for the instruction being executed: taken jumps load
  // the address field, HALT freezes the pc, everything else steps by one.
  always_comb begin
    w_pcNext = w_pcInc;
    if (!w_isLdi) begin
      case (w_op)
        OP_JMP:  w_pcNext = w_addr;
        OP_JZ:   if (r_regs[0] == '0) w_pcNext = w_addr;
        OP_HALT: w_pcNext = r_pc;
        default: w_pcNext = w_pcInc;
      endcase
    end
  end

  // State register; reset always returns the core to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_nextState;
  end

  // Next-state decode; EXEC branches on the opcode being executed.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH: w_nextState = EXEC;
      EXEC: begin
        if (w_isLdi)                w_nextState = FETCH;
        else if (w_op == OP_OUTR)   w_nextState = OUTW;
        else if (w_op == OP_OUTM)   w_nextState = MEMRD;
        else if (w_op == OP_HALT)   w_nextState = HALT;
        else                        w_nextState = FETCH;
      end
      MEMRD: w_nextState = OUTW;
      OUTW:  w_nextState = out_ready ? FETCH : OUTW;
      HALT:  w_nextState = HALT;
      default: w_nextState = FETCH;
    endcase
  end

  // Outputs. In the first OUTW cycle after MEMRD the memory word is only now on
  // imem_rdata, so it is forwarded directly while it is also being registered;
  // from the second cycle on the registered copy holds the value stable.
  always_comb begin
    imem_addr = (r_state == MEMRD) ? r_memAddr : r_pc;
    out_data  = r_capture ? imem_rdata : r_outData;
    out_valid = r_outValid;
    halted    = (r_state == HALT);
    pc        = r_pc;
  end

  // Datapath: register file, pc and output holding registers. Operands are read
  // from the current register values, so rd==rs sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_capture  <= 1'b0;
      r_memAddr  <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        EXEC: begin
          r_memAddr <= w_addr;
          r_pc      <= w_pcNext;
          if (w_isLdi) begin
            r_regs[w_ldiRd] <= DATA_W'(w_imm);
          end else begin
            case (w_op)
              OP_OUTR: begin
                r_outData  <= 16'(r_regs[w_rs]);
                r_outValid <= 1'b1;
              end
              OP_MOV:  r_regs[w_rd] <= r_regs[w_rs];
              OP_ADD:  r_regs[w_rd] <= r_regs[w_rd] + r_regs[w_rs];
              OP_SUB:  r_regs[w_rd] <= r_regs[w_rd] - r_regs[w_rs];
              default: ;
            endcase
          end
        end
        MEMRD: begin
          r_outValid <= 1'b1;
          r_capture  <= 1'b1;
        end
        OUTW: begin
          if (r_capture) begin
            r_outData <= imem_rdata;
            r_capture <= 1'b0;
          end
          if (out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
